// File: rtl/moddiv_param.sv
// Modular divider c = b * a^-1 mod m (odd m) via binary extended Euclid, start/busy/done handshake.
// Optional MODDIV_CYCLE_CNT_EN adds a 'cycles' port reporting LOOP cycles of the last operation.
module moddiv_param #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(4*WIDTH+4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             err
`ifdef MODDIV_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, LOOP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4*WIDTH+1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE   = WIDTH'(3);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, m_r, u, v, x1, x2;
    logic [WIDTH-1:0] a_n, m_n, u_n, v_n, x1_n, x2_n, c_n;
    logic             err_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // (x / 2) mod M; the odd case adds M at WIDTH+1 bits so the carry survives the shift
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] md);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    // p - q mod M for p, q in [0, M-1]; wraparound of the W-bit result cancels out
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] md);
        return (p >= q) ? (p - q) : (p - q + md);
    endfunction

    always_comb begin
        state_n = state;
        a_n     = a_r;
        m_n     = m_r;
        u_n     = u;
        v_n     = v;
        x1_n    = x1;
        x2_n    = x2;
        c_n     = c;
        err_n   = err;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CHECK;
                    a_n     = a;
                    m_n     = m;
                    u_n     = a;
                    v_n     = m;
                    x1_n    = b;
                    x2_n    = '0;
                    cnt_n   = '0;
                    c_n     = '0;
                    err_n   = 1'b0;
                end
            end
            CHECK: begin
                if (!m_r[0] || (m_r < THREE) || (a_r == '0)) begin
                    err_n   = 1'b1;
                    c_n     = '0;
                    state_n = DONE;
                end else begin
                    state_n = LOOP;
                end
            end
            LOOP: begin
                cnt_n = cnt + CNT_W'(1);
                if (u == ONE) begin
                    c_n     = x1;
                    state_n = DONE;
                end else if (v == ONE) begin
                    c_n     = x2;
                    state_n = DONE;
                end else if ((u == '0) || (v == '0)) begin
                    err_n   = 1'b1;
                    c_n     = '0;
                    state_n = DONE;
                end else if (cnt_n == CNT_MAX) begin
                    err_n   = 1'b1;
                    c_n     = '0;
                    state_n = DONE;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    x1_n = halve(x1, m_r);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    x2_n = halve(x2, m_r);
                end else if (u >= v) begin
                    u_n  = u - v;
                    x1_n = sub_mod(x1, x2, m_r);
                end else begin
                    v_n  = v - u;
                    x2_n = sub_mod(x2, x1, m_r);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            m_r   <= '0;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            c     <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            a_r   <= a_n;
            m_r   <= m_n;
            u     <= u_n;
            v     <= v_n;
            x1    <= x1_n;
            x2    <= x2_n;
            c     <= c_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end

    assign busy = (state == CHECK) || (state == LOOP);
    assign done = (state == DONE);

`ifdef MODDIV_CYCLE_CNT_EN
    // captured on entry to DONE so the count is valid alongside the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if ((state_n == DONE) && (state != DONE)) begin
            cycles <= cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_moddiv_param.sv
// Self-checking bench for moddiv_param at WIDTH=8 and WIDTH=256 against a brute-force inverse model.
// Covers the MODDIV_CYCLE_CNT_EN cycles port when that macro is defined.
module tb_moddiv_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, m8 = '0, c8;
    logic         busy8, done8, err8;
    logic         start2 = 1'b0;
    logic [255:0] a2 = '0, b2 = '0, m2 = '0, c2;
    logic         busy2, done2, err2;
`ifdef MODDIV_CYCLE_CNT_EN
    logic [5:0]   cyc8;
    logic [9:0]   cyc2;
`endif

    int checks = 0;
    int errors = 0;

    moddiv_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .m(m8),
        .busy(busy8), .done(done8), .c(c8), .err(err8)
`ifdef MODDIV_CYCLE_CNT_EN
        , .cycles(cyc8)
`endif
    );

    moddiv_param #(.WIDTH(256)) dut256 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .m(m2),
        .busy(busy2), .done(done2), .c(c2), .err(err2)
`ifdef MODDIV_CYCLE_CNT_EN
        , .cycles(cyc2)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: c = b * a^-1 mod m found by exhaustive search for the inverse.
    task automatic model8(input int a, input int b, input int m, output int c, output int e);
        int inv;
        inv = -1;
        c = 0;
        e = 1;
        if ((m % 2 == 1) && (m >= 3) && (a != 0)) begin
            for (int x = 1; x < m; x++)
                if (((a * x) % m) == 1) inv = x;
            if (inv >= 0) begin
                c = (b * inv) % m;
                e = 0;
            end
        end
    endtask

    task automatic run8(input int a, input int b, input int m, output int lat);
        @(negedge clk);
        a8 = 8'(a); b8 = 8'(b); m8 = 8'(m); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done8_timeout", done8, 1);
    endtask

    task automatic run256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m, output int lat);
        @(negedge clk);
        a2 = a; b2 = b; m2 = m; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 1200) begin
            @(negedge clk);
            lat++;
        end
        check("done256_timeout", done2, 1);
    endtask

    task automatic case8(input string tag, input int a, input int b, input int m);
        int lat, ec, ee;
        run8(a, b, m, lat);
        model8(a, b, m, ec, ee);
        check({tag, "_c"}, c8, ec);
        check({tag, "_err"}, err8, ee);
        check({tag, "_lat"}, lat <= 35, 1);
    endtask

    task automatic case256(input string tag, input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        int lat;
        logic [511:0] prod;
        run256(a, b, m, lat);
        prod = ({256'b0, c2} * {256'b0, a}) % {256'b0, m};
        check({tag, "_ca"}, prod[255:0], b);
        check({tag, "_err"}, err2, 0);
        check({tag, "_lat"}, lat <= 1027, 1);
    endtask

    initial begin
        int lat, ec, ee, ra, rb, rm;
        logic [255:0] p256, a256, rnd;

        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_c", c8, 0);
        check("rst_err", err8, 0);
        check("rst_busy256", busy2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        case8("m11_a3_b1", 3, 1, 11);
        check("m11_a3_b1_exact", c8, 4);
        case8("m11_a3_b2", 3, 2, 11);
        check("m11_a3_b2_exact", c8, 8);
        run8(1, 7, 11, lat);
        check("a1_c", c8, 7);
        check("a1_lat", lat, 3);
`ifdef MODDIV_CYCLE_CNT_EN
        check("a1_cycles", cyc8, 1);
`endif
        case8("m9_a3", 3, 1, 9);
        run8(0, 5, 9, lat);
        check("a0_err", err8, 1);
        check("a0_c", c8, 0);
        check("a0_lat", lat, 2);
        case8("m10_even", 3, 1, 10);
        check("m10_err", err8, 1);
        case8("m1", 0, 0, 1);
        check("m1_err", err8, 1);

        for (int a = 1; a <= 10; a++) begin
            case8("exh_m11", a, $urandom_range(0, 10), 11);
`ifdef MODDIV_CYCLE_CNT_EN
            check("exh_cycles", cyc8 <= 33, 1);
`endif
        end

        for (int i = 0; i < 40; i++) begin
            rm = $urandom_range(1, 127) * 2 + 1;
            ra = $urandom_range(0, rm - 1);
            rb = $urandom_range(0, rm - 1);
            case8("rand8", ra, rb, rm);
        end

        // start while busy must be ignored
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd1; m8 = 8'd11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd7; start8 = 1'b1;
        check("busy_during_loop", busy8, 1);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_done", done8, 1);
        check("ignore_c", c8, 4);
        @(negedge clk);
        @(negedge clk);
        check("ignore_no_rerun_busy", busy8, 0);
        check("ignore_no_rerun_done", done8, 0);

        // reset aborts mid-LOOP
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd1; m8 = 8'd11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", busy8, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_c", c8, 0);
        check("abort_err", err8, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done8, 0);
        end
        run8(5, 1, 11, lat);
        check("after_abort_c", c8, 9);
        check("after_abort_err", err8, 0);

        p256 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
        a256 = 256'hfd17fead63b0f73b1f25378af4f4ccf41a26e81bfae64b63492bf47d406c14ad;
        case256("k1_b1", a256, 256'd1, p256);
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
            if (rnd >= p256) rnd = rnd - p256;
            case256("k1_brand", a256, rnd, p256);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
